// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and imem driver with one-entry hold buffer and redirect squash
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        id_ready_i,
  output logic [8:0]  imem_addr_o,
  input  logic [31:0] imem_instr_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic        instr_valid_o,
  output logic        misaligned_o
);
  logic [31:0] issue_pc_q, issue_pc_d, resp_pc_q, resp_pc_d, hold_q, hold_d;
  logic        resp_valid_q, resp_valid_d, hold_valid_q, hold_valid_d, misaligned_q, misaligned_d;
  logic        advance;
  assign advance       = !resp_valid_q || id_ready_i;
  assign imem_addr_o   = issue_pc_q[10:2];
  assign instr_o       = hold_valid_q ? hold_q : imem_instr_i;
  assign pc_o          = resp_pc_q;
  assign instr_valid_o = resp_valid_q;
  assign misaligned_o  = misaligned_q;
  // a stall keeps issue_pc, so memory re-reads the word that follows the held one
  always_comb begin
    issue_pc_d   = redirect_i ? {redirect_pc_i[31:2], 2'b00} : advance ? issue_pc_q + 32'd4 : issue_pc_q;
    resp_pc_d    = (!redirect_i && advance) ? issue_pc_q : resp_pc_q;
    resp_valid_d = !redirect_i && (advance || resp_valid_q);
    hold_valid_d = !redirect_i && !advance;
    hold_d       = (!redirect_i && !advance && !hold_valid_q) ? imem_instr_i : hold_q;
    misaligned_d = redirect_i && |redirect_pc_i[1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_pc_q   <= RESET_PC;
      resp_pc_q    <= '0;
      hold_q       <= '0;
      resp_valid_q <= 1'b0;
      hold_valid_q <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      issue_pc_q   <= issue_pc_d;
      resp_pc_q    <= resp_pc_d;
      hold_q       <= hold_d;
      resp_valid_q <= resp_valid_d;
      hold_valid_q <= hold_valid_d;
      misaligned_q <= misaligned_d;
    end
  end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage that owns the program counter and drives the synchronous-read instruction memory (512 × 32-bit words, one-cycle read latency). It issues word addresses and tags each returned word with its PC. A one-entry hold buffer presents a stable instruction to decode under back-pressure. Branch/jump redirects from execute squash the in-flight fetch.

## Interface
- `RESET_PC`, default `32'h0000_0000`: byte PC issued first after reset; bits [1:0] are zero.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect_i`  in  1  take branch/jump this cycle.
- `redirect_pc_i`  in  32  byte target PC.
- `id_ready_i`  in  1  decode accepts the presented instruction this cycle.
- `imem_addr_o`  out  address_t (9)  word address to instruction memory, equal to `issue_pc[10:2]`.
- `imem_instr_i`  in  word_t (32)  memory data; returns the word addressed in the previous cycle.
- `instr_o`  out  32  instruction presented to decode.
- `pc_o`  out  32  byte PC of `instr_o`.
- `instr_valid_o`  out  1  `instr_o`/`pc_o` valid.
- `misaligned_o`  out  1  one-cycle pulse: the last redirect target had nonzero bits [1:0].

## Operation
- Registers:
  - `issue_pc` (32): PC currently driven to memory.
  - `resp_pc` (32) and `resp_valid`: the word on `imem_instr_i`.
  - `hold_q` (32) and `hold_valid`: the hold buffer.
  - `misaligned_q`.
- States are implied by the flags:
  - EMPTY: `resp_valid=0`.
  - STREAM: `resp_valid=1`, `hold_valid=0`.
  - HELD: `resp_valid=1`, `hold_valid=1`.
- Combinational outputs:
  - `instr_o = hold_valid ? hold_q : imem_instr_i`.
  - `pc_o = resp_pc`.
  - `instr_valid_o = resp_valid`.
- Define `advance = !resp_valid || id_ready_i`.
- Priority 1, `redirect_i` (overrides stall and advance):
  - `issue_pc <= {redirect_pc_i[31:2],2'b00}`.
  - `resp_valid <= 0`, `hold_valid <= 0`.
  - `misaligned_q <= |redirect_pc_i[1:0]`.
  - The instruction presented in the redirect cycle counts as consumed only if `id_ready_i=1`; otherwise it is discarded.
- Priority 2, `advance`:
  - `resp_pc <= issue_pc`, `resp_valid <= 1`.
  - `issue_pc <= issue_pc + 4` (mod 2^32).
  - `hold_valid <= 0`.
- Priority 3, stall (`resp_valid && !id_ready_i`):
  - If `hold_valid=0`: `hold_q <= imem_instr_i`, `hold_valid <= 1` (STREAM→HELD).
  - If already HELD: all registers hold.
  - `issue_pc` holds, so the memory re-reads the same word. That word is correct for `resp_pc+4` when the stall releases.
- `misaligned_q` clears on any non-redirect cycle. `misaligned_o = misaligned_q`.
- Address wrap: `imem_addr_o` uses PC bits [10:2], so sequential fetch wraps from word 511 to word 0 (`issue_pc` `0x7FC` → `0x800` maps to word 0).

## Timing
- Reset (async assert, any cycle, including mid-stall or mid-redirect):
  - `issue_pc=RESET_PC`, `resp_pc=0`.
  - `resp_valid=0`, `hold_valid=0`, `misaligned_q=0`.
  - `instr_valid_o=0`, `misaligned_o=0`.
  - `imem_addr_o=RESET_PC[10:2]`.
- Release: first rising edge after deassert is cycle 0, where `resp_valid=0` (EMPTY) and `advance=1`. Cycle 1: `instr_valid_o=1`, `pc_o=RESET_PC`, `instr_o=mem[RESET_PC>>2]`.
- Throughput: one instruction per cycle while `id_ready_i=1`.
- Redirect latency: redirect in cycle N gives `instr_valid_o=0` in N+1 and the target instruction in N+2. A further redirect in N+1 restarts the sequence.
- Stall: outputs stable for the whole stall. The cycle after `id_ready_i` returns high presents `resp_pc+4` with no bubble.
- Simultaneous `redirect_i` and `!id_ready_i`: the redirect wins and the hold buffer is flushed.

## Test plan
- Reset/stream: memory word k = `32'hA000_0000+k`, `RESET_PC=0`, `id_ready_i=1`.
  - Cycle 1 gives `pc_o=0`, `instr_o=A0000000`; each later cycle increments PC by 4 and data by 1.
  - `instr_valid_o=0` in cycle 0.
- Stall/hold: hold `id_ready_i=0` for 3 cycles while `pc_o=8`.
  - `instr_o=A0000002` and `pc_o=8` stay stable throughout.
  - On release the next cycle gives `pc_o=0xC`, `instr_o=A0000003`.
- Redirect: `redirect_i` with target `0x100` while streaming at `pc_o=0x10`.
  - Next cycle `instr_valid_o=0`.
  - The cycle after gives `pc_o=0x100`, `instr_o=A0000040`.
- Redirect during stall plus misalignment: in HELD, redirect with target `0x202`.
  - Hold buffer flushed; `misaligned_o=1` for exactly one cycle.
  - Two cycles later `pc_o=0x200`, `instr_o=A0000080`.
- Wrap and async reset:
  - Redirect to `0x7F8` and stream: words 510, 511, then word 0 at `pc_o=0x800`.
  - Assert `rst` mid-stall: `instr_valid_o` drops immediately, without waiting for a clock edge.
  - Fetch restarts at `RESET_PC`.
